// File: rtl/delay_mem_pkg.sv
// Shared types and helpers for the delay-line SRAM scheduler.
// Mix saturation is compiled in when DELAY_MEM_SAT_EN is defined.
package delay_mem_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned ACC_W    = 18;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR    = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Clamp an 18-bit accumulator into the 16-bit sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
    logic signed [SAMPLE_W-1:0] res;
    if (acc > 18'sd32767) begin
      res = SAT_MAX;
    end else if (acc < -18'sd32768) begin
      res = SAT_MIN;
    end else begin
      res = acc[SAMPLE_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mix_sat_adder.sv
// Combinational signed sum of N_IN packed samples in an 18-bit accumulator.
// DELAY_MEM_SAT_EN selects saturation; otherwise the result wraps.
module mix_sat_adder
  import delay_mem_pkg::*;
#(
  parameter int unsigned N_IN = 3
) (
  input  logic [N_IN*SAMPLE_W-1:0] in_vec,
  output logic [SAMPLE_W-1:0]      sum_c
);

  logic signed [ACC_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      acc = acc + ACC_W'($signed(in_vec[i*SAMPLE_W +: SAMPLE_W]));
    end
  end

`ifdef DELAY_MEM_SAT_EN
  assign sum_c = sat16(acc);
`else
  assign sum_c = acc[SAMPLE_W-1:0];
`endif

endmodule

// File: rtl/delay_mem_scheduler.sv
// Per-frame sequencer sharing one single-port delay SRAM between tap reads and
// the sample write. Mix saturation is enabled by defining DELAY_MEM_SAT_EN.
module delay_mem_scheduler
  import delay_mem_pkg::*;
#(
  parameter int unsigned N_TAPS = 2,
  parameter int unsigned AW     = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         ADCLRCK,
  input  logic [SAMPLE_W-1:0]          sample_in,
  input  logic [AW-1:0]                wr_ptr,
  input  logic [N_TAPS*AW-1:0]         delay,
  output logic [AW-1:0]                mem_addr,
  output logic [SAMPLE_W-1:0]          mem_wdata,
  output logic                         mem_we,
  output logic                         mem_re,
  input  logic [SAMPLE_W-1:0]          mem_rdata,
  output logic [N_TAPS*SAMPLE_W-1:0]   tap_out,
  output logic [SAMPLE_W-1:0]          mix_out,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int unsigned DR_W  = $clog2(RD_LAT + 1);

  state_e                            state_q, state_d;
  logic [IDX_W-1:0]                  rd_cnt_q, rd_cnt_d;
  logic [DR_W-1:0]                   dr_cnt_q, dr_cnt_d;
  logic [SAMPLE_W-1:0]               sample_q, sample_d;
  logic [AW-1:0]                     wr_ptr_q, wr_ptr_d;
  logic [N_TAPS-1:0][AW-1:0]         delay_q, delay_d;
  logic [AW-1:0]                     mem_addr_q, mem_addr_d;
  logic [SAMPLE_W-1:0]               mem_wdata_q, mem_wdata_d;
  logic                              mem_we_q, mem_we_d;
  logic                              mem_re_q, mem_re_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic [SAMPLE_W-1:0]               mix_q, mix_d;
  logic [RD_LAT:0]                   pv_q, pv_d;
  logic [RD_LAT:0][IDX_W-1:0]        pi_q, pi_d;
  logic [N_TAPS-1:0][SAMPLE_W-1:0]   tap_q, tap_d;

  logic [N_TAPS-1:0][AW-1:0]         dly_cur;
  logic [AW-1:0]                     wr_cur;
  logic [AW-1:0]                     eff_dly;
  logic [AW-1:0]                     rd_addr;
  logic [IDX_W-1:0]                  tap_idx;
  logic [SAMPLE_W-1:0]               mix_c;

  // The first read issues on the same edge the inputs are latched, so it uses the live inputs.
  always_comb begin
    wr_cur  = (state_q == IDLE) ? wr_ptr : wr_ptr_q;
    dly_cur = (state_q == IDLE) ? delay : delay_q;
    tap_idx = (state_q == IDLE) ? '0 : rd_cnt_q;
    eff_dly = dly_cur[tap_idx];
    if (eff_dly == '0) begin
      eff_dly = AW'(1);
    end
    rd_addr = wr_cur - eff_dly;
  end

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    dr_cnt_d    = dr_cnt_q;
    sample_d    = sample_q;
    wr_ptr_d    = wr_ptr_q;
    delay_d     = delay_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mix_d       = mix_q;
    tap_d       = tap_q;
    pv_d[0]     = 1'b0;
    pi_d[0]     = '0;
    for (int unsigned i = 1; i <= RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pi_d[i] = pi_q[i-1];
    end

    case (state_q)
      IDLE: begin
        sample_d   = sample_in;
        wr_ptr_d   = wr_ptr;
        delay_d    = delay;
        mem_addr_d = rd_addr;
        mem_re_d   = 1'b1;
        pv_d[0]    = 1'b1;
        pi_d[0]    = tap_idx;
        rd_cnt_d   = IDX_W'(1);
        state_d    = (N_TAPS == 1) ? WR : RD;
      end
      RD: begin
        mem_addr_d = rd_addr;
        mem_re_d   = 1'b1;
        pv_d[0]    = 1'b1;
        pi_d[0]    = tap_idx;
        rd_cnt_d   = rd_cnt_q + IDX_W'(1);
        if (rd_cnt_q == IDX_W'(N_TAPS - 1)) begin
          state_d = WR;
        end
      end
      WR: begin
        mem_addr_d  = wr_ptr_q;
        mem_wdata_d = sample_q;
        mem_we_d    = 1'b1;
        dr_cnt_d    = '0;
        state_d     = DRAIN;
      end
      DRAIN: begin
        if (dr_cnt_q == DR_W'(RD_LAT)) begin
          state_d = DONE;
        end else begin
          dr_cnt_d = dr_cnt_q + DR_W'(1);
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Tap index emerging from the latency pipeline tells which slot the SRAM data belongs to.
    if (pv_q[RD_LAT]) begin
      tap_d[pi_q[RD_LAT]] = mem_rdata;
    end

    busy_d = (state_d == RD) || (state_d == WR) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    if ((state_d == DONE) && (state_q != DONE)) begin
      mix_d = mix_c;
    end
  end

  always_ff @(posedge clk or posedge ADCLRCK) begin
    if (ADCLRCK) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      dr_cnt_q    <= '0;
      sample_q    <= '0;
      wr_ptr_q    <= '0;
      delay_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mix_q       <= '0;
      pv_q        <= '0;
      pi_q        <= '0;
      tap_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      dr_cnt_q    <= dr_cnt_d;
      sample_q    <= sample_d;
      wr_ptr_q    <= wr_ptr_d;
      delay_q     <= delay_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mix_q       <= mix_d;
      pv_q        <= pv_d;
      pi_q        <= pi_d;
      tap_q       <= tap_d;
    end
  end

  mix_sat_adder #(
    .N_IN (N_TAPS + 1)
  ) u_mix (
    .in_vec ({tap_q, sample_q}),
    .sum_c  (mix_c)
  );

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign tap_out   = tap_q;
  assign mix_out   = mix_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
